// File: rtl/wb_bus_router_pkg.sv
// +----------------------------------------------------------------------+
// | wb_bus_router_pkg : shared state encoding and slot map for the router |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package wb_bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } router_state_t;

  // Fill bit for read data returned alongside an error response.
  localparam logic WB_ERR_DATA = 1'b0;

  // Default slot assignment of the peripheral set.
  localparam int unsigned SLOT_PCFG  = 0;
  localparam int unsigned SLOT_MQ    = 1;
  localparam int unsigned SLOT_SSTEP = 2;
  localparam int unsigned SLOT_CNTR  = 3;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
// +----------------------------------------------------------------------+
// | wb_timeout_ctr : counts ACTIVE cycles, flags the last permitted cycle |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/wb_bus_router.sv
// +----------------------------------------------------------------------+
// | wb_bus_router : registered Wishbone 1-master / N-slave router with    |
// |                 unmapped/timeout errors, abort and error counter      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_bus_router
  import wb_bus_router_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 7,
  parameter int SLV_ADDR_W = 4,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int ERRCNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_stb_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_we_i,
  input  logic [ADDR_W-1:0]            wb_adr_i,
  input  logic [DATA_W-1:0]            wb_dat_i,
  output logic [DATA_W-1:0]            wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic [NUM_SLAVES-1:0]        s_wb_stb_o,
  output logic [NUM_SLAVES-1:0]        s_wb_cyc_o,
  output logic                         s_wb_we_o,
  output logic [SLV_ADDR_W-1:0]        s_wb_adr_o,
  output logic [DATA_W-1:0]            s_wb_dat_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_wb_ack_i,
  output logic [ERRCNT_W-1:0]          err_count
);

  localparam int SLOT_W = ADDR_W - SLV_ADDR_W;

  router_state_t state, state_nxt;

  logic [SLOT_W-1:0]     req_slot;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  req_mapped;
  logic                  sel_ack;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  tmo_expired;

  logic [NUM_SLAVES-1:0] stb_nxt;
  logic                  ack_nxt;
  logic                  err_nxt;
  logic [DATA_W-1:0]     dat_nxt;
  logic                  load_req;
  logic                  ctr_clear;

  assign req_slot = wb_adr_i[ADDR_W-1:SLV_ADDR_W];

  // A slot index with no populated slave decodes to all-zero, i.e. unmapped.
  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (req_slot == SLOT_W'(k)) begin
        req_onehot[k] = 1'b1;
      end
    end
  end

  assign req_mapped = |req_onehot;

  // Only the selected slave's ack and data count; the strobe register is the selector.
  assign sel_ack = |(s_wb_ack_i & s_wb_stb_o);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_wb_stb_o[k]) begin
        sel_rdata = sel_rdata | s_wb_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ctr_clear),
    .enable  (state == ST_ACTIVE),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stb_nxt   = '0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = '0;
    load_req  = 1'b0;
    ctr_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
          load_req = 1'b1;
          if (req_mapped) begin
            state_nxt = ST_ACTIVE;
            stb_nxt   = req_onehot;
            ctr_clear = 1'b1;
          end else begin
            state_nxt = ST_RESP;
            err_nxt   = 1'b1;
            dat_nxt   = {DATA_W{WB_ERR_DATA}};
          end
        end
      end
      ST_ACTIVE: begin
        stb_nxt = s_wb_stb_o;
        // Abort beats ack, and ack beats timeout.
        if (!wb_cyc_i) begin
          state_nxt = ST_IDLE;
          stb_nxt   = '0;
        end else if (sel_ack) begin
          state_nxt = ST_RESP;
          stb_nxt   = '0;
          ack_nxt   = 1'b1;
          dat_nxt   = s_wb_we_o ? '0 : sel_rdata;
        end else if (tmo_expired) begin
          state_nxt = ST_RESP;
          stb_nxt   = '0;
          err_nxt   = 1'b1;
          dat_nxt   = {DATA_W{WB_ERR_DATA}};
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_wb_stb_o <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      s_wb_we_o  <= 1'b0;
      s_wb_adr_o <= '0;
      s_wb_dat_o <= '0;
      err_count  <= '0;
    end else begin
      s_wb_stb_o <= stb_nxt;
      wb_ack_o   <= ack_nxt;
      wb_err_o   <= err_nxt;
      wb_dat_o   <= dat_nxt;
      if (load_req) begin
        s_wb_we_o  <= wb_we_i;
        s_wb_adr_o <= wb_adr_i[SLV_ADDR_W-1:0];
        s_wb_dat_o <= wb_dat_i;
      end
      if (err_nxt && (err_count != {ERRCNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  assign s_wb_cyc_o = s_wb_stb_o;

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_router.sv
// +----------------------------------------------------------------------+
// | tb_wb_bus_router : table + random transactions against a txn model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_wb_bus_router;
  import wb_bus_router_pkg::*;

  localparam int NS  = 4;
  localparam int AW  = 7;
  localparam int SAW = 4;
  localparam int DW  = 32;
  localparam int TO  = 16;
  localparam int EW  = 8;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] mdat;

  logic [DW-1:0]    dat_o;
  logic             ack, err;
  logic [NS-1:0]    s_stb, s_cyc;
  logic             s_we;
  logic [SAW-1:0]   s_adr;
  logic [DW-1:0]    s_dat;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack;
  logic [EW-1:0]    errcnt;

  logic [DW-1:0]    d2_dat_o;
  logic             ack2, err2;
  logic [NS-1:0]    d2_stb, d2_cyc;
  logic             d2_we;
  logic [SAW-1:0]   d2_adr;
  logic [DW-1:0]    d2_dat;
  logic [1:0]       errcnt2;

  wb_bus_router #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .SLV_ADDR_W(SAW), .DATA_W(DW), .TIMEOUT(TO), .ERRCNT_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(mdat), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc), .s_wb_we_o(s_we), .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_dat), .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack), .err_count(errcnt)
  );

  // Narrow error counter copy, used for the saturation check.
  wb_bus_router #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .SLV_ADDR_W(SAW), .DATA_W(DW), .TIMEOUT(TO), .ERRCNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(mdat), .wb_dat_o(d2_dat_o), .wb_ack_o(ack2), .wb_err_o(err2),
    .s_wb_stb_o(d2_stb), .s_wb_cyc_o(d2_cyc), .s_wb_we_o(d2_we), .s_wb_adr_o(d2_adr),
    .s_wb_dat_o(d2_dat), .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack), .err_count(errcnt2)
  );

  // Slave model: the selected slave acks once its strobe has been high for delay_cur cycles.
  int            delay_cur;
  int            scnt [NS];
  logic [DW-1:0] slave_data [NS];
  logic [NS-1:0] slv_ack;
  logic [NS-1:0] noise;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      scnt[k] <= s_stb[k] ? scnt[k] + 1 : 0;
    end
  end

  always_comb begin
    slv_ack = '0;
    s_dat_i = '0;
    for (int k = 0; k < NS; k++) begin
      slv_ack[k] = s_stb[k] && (scnt[k] == delay_cur);
      s_dat_i[k*DW +: DW] = slave_data[k];
    end
    s_ack = slv_ack | (noise & ~s_stb);
  end

  int compared = 0;
  int mismatched = 0;
  int errs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level prediction: outcome kind, response cycle, last slave-strobe cycle, data.
  task automatic predict(input logic [AW-1:0] a, input logic w, input int dly, input int abort_at,
                         input logic [DW-1:0] sd, output int kind, output int r, output int l,
                         output logic [DW-1:0] ed);
    int slot;
    slot = int'(a[AW-1:SAW]);
    ed = '0;
    if (slot >= NS) begin
      kind = K_ERR; r = 1; l = 0;
    end else if (abort_at > 0) begin
      kind = K_NONE; r = 0; l = abort_at;
    end else if (dly <= TO - 1) begin
      kind = K_ACK; r = dly + 2; l = r - 1;
      ed = w ? '0 : sd;
    end else begin
      kind = K_ERR; r = TO + 1; l = TO;
    end
  endtask

  task automatic run_txn(input string name, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] md, input int dly, input int abort_at,
                         input logic [DW-1:0] sd, input int kind, input int r, input int l,
                         input logic [DW-1:0] ed);
    int slot, n, e1, e2;
    logic [NS-1:0] oh, exp_stb;
    logic [DW-1:0] exp_dat;
    slot = int'(a[AW-1:SAW]);
    oh = (slot < NS) ? (NS'(1) << slot) : '0;
    delay_cur = dly;
    for (int k = 0; k < NS; k++) slave_data[k] = $urandom;
    if (slot < NS) slave_data[slot] = sd;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; mdat = md;
    noise = NS'($urandom);
    n = ((r > l) ? r : l) + 2;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp_stb = (c >= 1 && c <= l) ? oh : '0;
      exp_dat = (kind == K_ACK && c == r) ? ed : '0;
      check($sformatf("%s cyc%0d ack/err/dat/stb", name, c),
            128'({ack, err, dat_o, s_stb, s_cyc, ack2, err2}),
            128'({kind == K_ACK && c == r, kind == K_ERR && c == r, exp_dat, exp_stb, exp_stb,
                  kind == K_ACK && c == r, kind == K_ERR && c == r}));
      if (exp_stb != '0)
        check($sformatf("%s cyc%0d we/adr/dat", name, c),
              128'({s_we, s_adr, s_dat}), 128'({w, a[SAW-1:0], md}));
      @(posedge clk); #1;
      noise = NS'($urandom);
      if ((abort_at > 0 && c + 1 == abort_at) || (kind != K_NONE && c + 1 == r + 1)) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    if (kind == K_ERR) errs++;
    e1 = (errs > 255) ? 255 : errs;
    e2 = (errs > 3) ? 3 : errs;
    check({name, " err_count"}, 128'(errcnt), 128'(e1));
    check({name, " err_count_sat"}, 128'(errcnt2), 128'(e2));
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] mdat;
    int            dly;
    int            abort_at;
    logic [DW-1:0] sdat;
    int            kind;
    int            r;
    int            l;
    logic [DW-1:0] edat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [AW-1:0] ra;
    logic          rw;
    logic [DW-1:0] rmd, rsd, red;
    int            rdly, rab, rk, rr, rl, mx;

    cyc = 0; stb = 0; we = 0; adr = '0; mdat = '0; noise = '0; delay_cur = 0;
    for (int k = 0; k < NS; k++) slave_data[k] = '0;

    tbl[0] = '{"rd_slot2", {3'(SLOT_SSTEP), 4'h3}, 1'b0, 32'h0, 3, 0, 32'hCAFEF00D, K_ACK, 5, 4, 32'hCAFEF00D};
    tbl[1] = '{"wr_slot0", {3'(SLOT_PCFG), 4'h5}, 1'b1, 32'h12345678, 0, 0, 32'h55AA55AA, K_ACK, 2, 1, 32'h0};
    tbl[2] = '{"unmapped5", 7'h50, 1'b0, 32'h0, 0, 0, 32'h0, K_ERR, 1, 0, 32'h0};
    tbl[3] = '{"timeout1", {3'(SLOT_MQ), 4'hA}, 1'b0, 32'h0, 99, 0, 32'h11111111, K_ERR, 17, 16, 32'h0};
    tbl[4] = '{"abort3", {3'(SLOT_CNTR), 4'h7}, 1'b1, 32'hDEAD0001, 10, 3, 32'h0, K_NONE, 0, 3, 32'h0};
    tbl[5] = '{"ack_on_tmo", {3'(SLOT_CNTR), 4'hF}, 1'b0, 32'h0, 15, 0, 32'h0BADBEEF, K_ACK, 17, 16, 32'h0BADBEEF};
    tbl[6] = '{"unmapped7", 7'h7F, 1'b1, 32'hFFFFFFFF, 0, 0, 32'h0, K_ERR, 1, 0, 32'h0};
    tbl[7] = '{"rd_slot0", {3'(SLOT_PCFG), 4'hC}, 1'b0, 32'h0, 1, 0, 32'h0000A5A5, K_ACK, 3, 2, 32'h0000A5A5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 128'({ack, err, dat_o, s_stb, s_cyc, s_we, s_adr, s_dat, errcnt, errcnt2}), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].name, tbl[i].adr, tbl[i].we, tbl[i].mdat, tbl[i].dly, tbl[i].abort_at,
              tbl[i].sdat, tbl[i].kind, tbl[i].r, tbl[i].l, tbl[i].edat);

    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom); rw = 1'($urandom); rmd = $urandom; rsd = $urandom;
      rdly = ($urandom % 8 < 6) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 18));
      rab = 0;
      if (int'(ra[AW-1:SAW]) < NS && rdly >= 1 && ($urandom % 6) == 0) begin
        mx = (rdly < TO) ? rdly : TO;
        rab = int'($urandom_range(1, mx));
      end
      predict(ra, rw, rdly, rab, rsd, rk, rr, rl, red);
      run_txn($sformatf("rnd%0d", i), ra, rw, rmd, rdly, rab, rsd, rk, rr, rl, red);
    end

    // Asynchronous reset in the middle of an ACTIVE transfer.
    delay_cur = 99;
    @(posedge clk); #1;
    cyc = 1; stb = 1; adr = 7'h11; we = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_active_reset", 128'({ack, err, dat_o, s_stb, s_cyc, s_we, s_adr, s_dat, errcnt, errcnt2}), 128'(0));
    cyc = 0; stb = 0;
    errs = 0;
    @(negedge clk);
    rst_n = 1'b1;

    predict(7'h24, 1'b0, 2, 0, 32'h600DF00D, rk, rr, rl, red);
    run_txn("after_reset", 7'h24, 1'b0, 32'h0, 2, 0, 32'h600DF00D, rk, rr, rl, red);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
